timer_ctrl: RTL
===============

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, counter and period width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; asserted when 0.
REQ-004 start  input  1  launch from IDLE/DONE, resume from PAUSE.
REQ-005 stop  input  1  pause a running count.
REQ-006 clear  input  1  abort to IDLE, count to 0.
REQ-007 mode  input  1  0 = one-shot, 1 = periodic.
REQ-008 period  input  WIDTH  terminal count; count runs 0..period-1.
REQ-009 count  output  WIDTH  current counter value.
REQ-010 busy  output  1  high in RUN or PAUSE.
REQ-011 tick  output  1  one-cycle pulse per completed period.
REQ-012 done  output  1  high while in DONE (one-shot finished).
REQ-013 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-015 In IDLE or DONE, start with period != 0 SHALL do all of the following at the next edge:
- latch period and mode;
- set count = 0;
- enter RUN.
REQ-016 In IDLE or DONE, start with period == 0 SHALL pulse err for one cycle and leave state and count unchanged.
REQ-017 In RUN, count SHALL increment by 1 per advance cycle: every cycle, or per prescaler (REQ-029).
REQ-018 On an advance with count == latched_period-1, count SHALL wrap to 0 and tick SHALL be 1 for the following cycle.
REQ-019 On that wrap, periodic mode SHALL stay in RUN; one-shot SHALL enter DONE with count = 0.
REQ-020 The latched period of 1 SHALL give tick every advance cycle, with count constantly 0.
REQ-021 In RUN, stop SHALL enter PAUSE and hold count; no tick is generated while paused.
REQ-022 In PAUSE, start SHALL return to RUN, continuing from the held count.
REQ-023 When start and stop are asserted in the same cycle, stop SHALL win; start is ignored.
REQ-024 clear SHALL take priority over start and stop: next state IDLE, count 0, tick 0.
REQ-025 Changes on period or mode while busy SHALL be ignored until the next launch.
REQ-026 count SHALL wrap modulo 2^WIDTH, so period = all-ones is legal.

Reset
REQ-027 While reset == 0 at an edge, the block SHALL set:
- state IDLE;
- count 0, latched period 0, latched mode 0;
- busy, tick, done and err all 0.
REQ-028 Reset SHALL abort any operation mid-count, with no tick or done emitted.

Configuration
REQ-029 With TIMER_CTRL_PRESCALE_EN defined:
- input presc[7:0] SHALL be present and latched at launch;
- an internal divider SHALL advance count once every presc+1 RUN cycles;
- the divider SHALL be cleared on launch, clear and reset, and held in PAUSE.
REQ-030 Without TIMER_CTRL_PRESCALE_EN, the presc port and the divider SHALL be absent, and every RUN cycle SHALL be an advance.

Structure
REQ-031 Package timer_pkg SHALL hold:
- the FSM state enum;
- the mode encoding constants (MODE_ONESHOT, MODE_PERIODIC);
- the default WIDTH.
REQ-032 The datapath SHALL be sub-module timer_cnt: a WIDTH-bit up counter with synchronous clear, enable and wrap-to-zero.
REQ-033 timer_ctrl SHALL contain the FSM, latch registers, the optional prescaler and output registers.

Verification
REQ-034 The bench SHALL cover the following scenarios:
- Periodic, period=3, start for 1 cycle -> count 0,1,2,0,...; tick high one cycle after each 2->0 wrap; busy=1.
- One-shot, period=5, start -> tick once after count 4; done=1, busy=0, count=0, held until the next start.
- Periodic, period=10, run to count=4, stop -> count holds at 4 for 6 cycles; start -> resumes 5,6,...
- start with period=0 -> err pulses for 1 cycle; state IDLE, count 0.
- Run to count=7, drive reset=0 for 1 cycle -> all outputs 0, IDLE, no tick; also start+stop together in RUN -> PAUSE.
- With TIMER_CTRL_PRESCALE_EN, presc=2, period=2 -> count advances every 3 cycles; tick every 6 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer_ctrl block: FSM states,
// mode encoding and the default counter width.
package timer_pkg;
  localparam int   DEFAULT_WIDTH = 32;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;
endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle of timer_ctrl. presc exists only when
// TIMER_CTRL_PRESCALE_EN is defined.
interface timer_ctrl_if import timer_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) ();
  logic             start;
  logic             stop;
  logic             clear;
  logic             mode;
  logic [WIDTH-1:0] period;
`ifdef TIMER_CTRL_PRESCALE_EN
  logic [7:0]       presc;
`endif
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;
  logic             err;

  modport master (
`ifdef TIMER_CTRL_PRESCALE_EN
    output presc,
`endif
    output start, stop, clear, mode, period,
    input  count, busy, tick, done, err
  );

  modport slave (
`ifdef TIMER_CTRL_PRESCALE_EN
    input  presc,
`endif
    input  start, stop, clear, mode, period,
    output count, busy, tick, done, err
  );
endinterface

// File: rtl/timer_cnt.sv
// WIDTH-bit up counter with synchronous clear, enable and wrap-to-zero.
module timer_cnt import timer_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             wrap,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)     count_d = '0;
    else if (en) count_d = wrap ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/timer_ctrl.sv
// Timer FSM (IDLE/RUN/PAUSE/DONE) with one-shot/periodic modes.
// Define TIMER_CTRL_PRESCALE_EN to add the presc-driven advance divider.
module timer_ctrl import timer_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic        clk,
  input logic        reset,
  timer_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d, err_q, err_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             cnt_clr, cnt_en, cnt_wrap, launch, run_step, div_hit;
  logic [WIDTH-1:0] count;

`ifdef TIMER_CTRL_PRESCALE_EN
  logic [7:0] presc_q, presc_d, div_q, div_d;
  assign div_hit = (div_q == presc_q);

  // Divider restarts on launch/clear and freezes whenever RUN is not stepping.
  always_comb begin
    presc_d = presc_q;
    div_d   = div_q;
    if (bus.clear || launch) begin
      div_d = '0;
      if (launch) presc_d = bus.presc;
    end else if (run_step) begin
      div_d = div_hit ? 8'd0 : div_q + 8'd1;
    end
  end
`else
  assign div_hit = 1'b1;
`endif

  assign run_step = (state_q == ST_RUN) && !bus.stop && !bus.clear;

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    err_d    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    cnt_wrap = 1'b0;
    launch   = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (bus.start) begin
          if (bus.period != '0) begin
            launch   = 1'b1;
            period_d = bus.period;
            mode_d   = bus.mode;
            cnt_clr  = 1'b1;
            state_d  = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
        ST_RUN: if (bus.stop) begin
          state_d = ST_PAUSE;
        end else if (div_hit) begin
          cnt_en = 1'b1;
          if (count == period_q - WIDTH'(1)) begin
            cnt_wrap = 1'b1;
            tick_d   = 1'b1;
            if (mode_q == MODE_ONESHOT) state_d = ST_DONE;
          end
        end
        ST_PAUSE: if (bus.start && !bus.stop) state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TIMER_CTRL_PRESCALE_EN
      presc_q  <= '0;
      div_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TIMER_CTRL_PRESCALE_EN
      presc_q  <= presc_d;
      div_q    <= div_d;
`endif
    end
  end

  timer_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .wrap  (cnt_wrap),
    .count (count)
  );

  assign bus.count = count;
  assign bus.busy  = busy_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
endmodule
